// File: rtl/decim_ser_pkg.sv
// ---------------------------------------------------------------------------
// decim_ser_pkg
// Shared types and helpers for the decimator output serializer.
//   ser_state_t     : serializer FSM states
//   SAT_W           : working width used by the saturation helper
//   level_w()       : width of a 0..depth occupancy count
//   cnt_w()         : width of a 0..n-1 counter, never below 1 bit
//   saturate_to_out : clamps a signed value to the signed out_w range
// ---------------------------------------------------------------------------
package decim_ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } ser_state_t;

  // Inputs are sign-extended to this width before clamping so the helper
  // serves any DATA_W/OUT_W pair up to 64 bits.
  localparam int SAT_W = 64;

  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Result is the clamped value in SAT_W bits; callers keep the low out_w.
  function automatic logic [SAT_W-1:0] saturate_to_out(
    input logic signed [SAT_W-1:0] value,
    input int                      out_w
  );
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = $signed((64'd1 << (out_w - 1)) - 64'd1);
    min_v = -max_v - 64'sd1;
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/decim_ser_fifo.sv
// ---------------------------------------------------------------------------
// decim_ser_fifo
// Single-clock sample FIFO with registered (block-RAM style) read port.
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_push, i_push_data : write request and data
//   i_pop               : read request (advances the head)
//   o_pop_data          : head entry, registered; reflects the head one
//                         cycle after a write or pointer change
//   o_full, o_empty     : occupancy flags
//   o_level             : entries held
// A push while full is accepted only when a pop happens in the same cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module decim_ser_fifo
  import decim_ser_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_push,
  input  logic [WIDTH-1:0]          i_push_data,
  input  logic                      i_pop,
  output logic [WIDTH-1:0]          o_pop_data,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [level_w(DEPTH)-1:0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;

  logic w_do_push;
  logic w_do_pop;

  assign o_full     = (r_level == LW'(DEPTH));
  assign o_empty    = (r_level == '0);
  assign w_do_pop   = i_pop && !o_empty;
  // A pop frees the slot the full-case push overwrites; the head value was
  // already captured in r_rd_data on the previous edge.
  assign w_do_push  = i_push && (!o_full || w_do_pop);
  assign o_pop_data = r_rd_data;
  assign o_level    = r_level;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage carries no reset so it maps onto RAM primitives.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    r_rd_data <= r_mem[r_rd_ptr];
  end

endmodule

// File: rtl/decim_sample_serializer.sv
// ---------------------------------------------------------------------------
// decim_sample_serializer
// Output stage after the decimation filter: saturates each sample to OUT_W
// bits, buffers it, and shifts it out MSB first as a serial frame.
//   i_clk, i_reset  : clock, synchronous active-high reset
//   i_din           : signed filter sample (DATA_W)
//   i_din_valid     : one-cycle sample strobe
//   i_enable        : allows new frames to start
//   o_sck           : serial clock, SCK_DIV clk cycles per half period
//   o_sdata         : serial data, changes while sck is low
//   o_fs            : frame sync, high for the MSB bit period
//   o_fifo_level    : samples buffered
//   o_overflow      : sticky, a sample was dropped on a full FIFO
//   o_busy          : serializer not idle
// Build option: define SERIALIZER_PARITY_EN to append an even-parity bit
// after the LSB of every frame.
// ---------------------------------------------------------------------------
module decim_sample_serializer
  import decim_ser_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int OUT_W      = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int SCK_DIV    = 4,
  parameter int GAP_CYC    = 2
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [DATA_W-1:0]              i_din,
  input  logic                           i_din_valid,
  input  logic                           i_enable,
  output logic                           o_sck,
  output logic                           o_sdata,
  output logic                           o_fs,
  output logic [level_w(FIFO_DEPTH)-1:0] o_fifo_level,
  output logic                           o_overflow,
  output logic                           o_busy
);

`ifdef SERIALIZER_PARITY_EN
  localparam int NBITS = OUT_W + 1;
`else
  localparam int NBITS = OUT_W;
`endif
  localparam int DIV_W = cnt_w(SCK_DIV);
  localparam int BIT_W = cnt_w(NBITS);
  localparam int GAP_W = cnt_w(GAP_CYC);

  // -------------------------------------------------------------------------
  // Input saturation and FIFO
  // -------------------------------------------------------------------------
  logic signed [SAT_W-1:0] w_din_ext;
  logic [OUT_W-1:0]        w_din_sat;
  logic [OUT_W-1:0]        w_head;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;
  logic                    w_drop;
  logic [NBITS-1:0]        w_frame;

  assign w_din_ext = SAT_W'($signed(i_din));
  assign w_din_sat = OUT_W'(saturate_to_out(w_din_ext, OUT_W));

  decim_ser_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (i_din_valid),
    .i_push_data (w_din_sat),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (o_fifo_level)
  );

`ifdef SERIALIZER_PARITY_EN
  assign w_frame = {w_head, ^w_head};
`else
  assign w_frame = w_head;
`endif

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  ser_state_t r_state;
  ser_state_t w_state_next;

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_next;
  logic [BIT_W-1:0] r_bit;
  logic [BIT_W-1:0] w_bit_next;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] w_gap_next;
  logic [NBITS-1:0] r_shift;
  logic [NBITS-1:0] w_shift_next;
  logic             r_sck;
  logic             w_sck_next;
  logic             r_sdata;
  logic             w_sdata_next;
  logic             r_fs;
  logic             w_fs_next;
  logic             r_busy;
  logic             r_overflow;

  logic w_half_end;
  logic w_last_bit;
  logic w_gap_end;
  logic w_start_ok;

  assign w_half_end = (r_div == DIV_W'(SCK_DIV - 1));
  assign w_last_bit = (r_bit == BIT_W'(NBITS - 1));
  assign w_gap_end  = (r_gap == GAP_W'(GAP_CYC - 1));
  assign w_start_ok = i_enable && !w_empty;
  assign w_pop      = (r_state == ST_LOAD);
  // The LOAD pop frees a slot in the same cycle, so that write is kept.
  assign w_drop     = i_din_valid && w_full && !w_pop;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_ok) w_state_next = ST_LOAD;
      ST_LOAD:  w_state_next = ST_SHIFT;
      ST_SHIFT: if (w_half_end && r_sck && w_last_bit) w_state_next = ST_GAP;
      ST_GAP:   if (w_gap_end) w_state_next = w_start_ok ? ST_LOAD : ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Next values of the divider, bit counter, shift register and the
  // registered serial outputs.
  always_comb begin
    w_div_next   = r_div;
    w_bit_next   = r_bit;
    w_gap_next   = r_gap;
    w_shift_next = r_shift;
    w_sck_next   = r_sck;
    w_sdata_next = r_sdata;
    w_fs_next    = r_fs;
    case (r_state)
      ST_IDLE: begin
        w_sck_next   = 1'b0;
        w_sdata_next = 1'b0;
        w_fs_next    = 1'b0;
      end
      ST_LOAD: begin
        w_shift_next = w_frame;
        w_sdata_next = w_frame[NBITS-1];
        w_fs_next    = 1'b1;
        w_sck_next   = 1'b0;
        w_div_next   = '0;
        w_bit_next   = '0;
      end
      ST_SHIFT: begin
        if (w_half_end) begin
          w_div_next = '0;
          if (!r_sck) begin
            w_sck_next = 1'b1;
          end else begin
            // Falling edge: advance to the next bit while sck is low.
            w_sck_next = 1'b0;
            w_fs_next  = 1'b0;
            if (w_last_bit) begin
              w_sdata_next = 1'b0;
              w_gap_next   = '0;
            end else begin
              w_bit_next   = r_bit + 1'b1;
              w_shift_next = {r_shift[NBITS-2:0], 1'b0};
              w_sdata_next = r_shift[NBITS-2];
            end
          end
        end else begin
          w_div_next = r_div + 1'b1;
        end
      end
      ST_GAP: begin
        w_sck_next = 1'b0;
        if (!w_gap_end) w_gap_next = r_gap + 1'b1;
      end
      default: begin
        w_sck_next   = 1'b0;
        w_sdata_next = 1'b0;
        w_fs_next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div      <= '0;
      r_bit      <= '0;
      r_gap      <= '0;
      r_shift    <= '0;
      r_sck      <= 1'b0;
      r_sdata    <= 1'b0;
      r_fs       <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_div      <= w_div_next;
      r_bit      <= w_bit_next;
      r_gap      <= w_gap_next;
      r_shift    <= w_shift_next;
      r_sck      <= w_sck_next;
      r_sdata    <= w_sdata_next;
      r_fs       <= w_fs_next;
      r_busy     <= (w_state_next != ST_IDLE);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign o_sck      = r_sck;
  assign o_sdata    = r_sdata;
  assign o_fs       = r_fs;
  assign o_busy     = r_busy;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_decim_sample_serializer.sv
// ---------------------------------------------------------------------------
// tb_decim_sample_serializer
// Scenario tasks drive the serializer; a receiver process rebuilds frames
// from sdata at sck rises and logs fs rise / final sck fall cycles. Expected
// words come from a saturation + parity model of the sample stream.
// ---------------------------------------------------------------------------
module tb_decim_sample_serializer;

  localparam int DATA_W     = 32;
  localparam int OUT_W      = 24;
  localparam int FIFO_DEPTH = 8;
  localparam int SCK_DIV    = 4;
  localparam int GAP_CYC    = 2;
`ifdef SERIALIZER_PARITY_EN
  localparam int NBITS = OUT_W + 1;
`else
  localparam int NBITS = OUT_W;
`endif
  localparam int SHIFT_CYC = 2 * SCK_DIV * NBITS;
  localparam int FRAME_BUDGET = SHIFT_CYC + GAP_CYC + 20;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              enable = 1'b0;
  logic              sck, sdata, fs, overflow, busy;
  logic [3:0]        fifo_level;

  always #5 clk = ~clk;

  decim_sample_serializer #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .FIFO_DEPTH(FIFO_DEPTH),
    .SCK_DIV(SCK_DIV), .GAP_CYC(GAP_CYC)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_din(din), .i_din_valid(din_valid),
    .i_enable(enable), .o_sck(sck), .o_sdata(sdata), .o_fs(fs),
    .o_fifo_level(fifo_level), .o_overflow(overflow), .o_busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Receiver state
  logic [31:0] rx_q[$];
  logic [31:0] fsp_q[$];
  int          rise_q[$];
  int          fall_q[$];
  logic [31:0] m_word = '0;
  logic [31:0] m_fs = '0;
  int          m_bits = 0;
  bit          m_prev_sck = 0;
  bit          m_prev_fs = 0;
  bit          m_pend = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (reset) begin
      m_word = '0; m_fs = '0; m_bits = 0; m_pend = 0;
      m_prev_sck = 0; m_prev_fs = 0;
    end else begin
      if (fs && !m_prev_fs) rise_q.push_back(cyc);
      if (sck && !m_prev_sck) begin
        m_word = {m_word[30:0], sdata};
        m_fs   = {m_fs[30:0], fs};
        m_bits++;
        if (m_bits == NBITS) begin
          rx_q.push_back(m_word);
          fsp_q.push_back(m_fs);
          m_word = '0; m_fs = '0; m_bits = 0; m_pend = 1;
        end
      end
      if (!sck && m_prev_sck && m_pend) begin
        fall_q.push_back(cyc);
        m_pend = 0;
      end
      m_prev_sck = sck;
      m_prev_fs  = fs;
    end
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference: clamp to the signed OUT_W range, then append even parity.
  function automatic logic [31:0] exp_word(input logic [31:0] d);
    longint      v, maxv, minv;
    logic [31:0] s;
    v    = longint'($signed(d));
    maxv = (longint'(1) << (OUT_W - 1)) - 1;
    minv = -maxv - 1;
    if (v > maxv) v = maxv;
    else if (v < minv) v = minv;
    s = 32'(v) & ((32'd1 << OUT_W) - 1);
`ifdef SERIALIZER_PARITY_EN
    s = (s << 1) | 32'($countones(s) & 1);
`endif
    return s;
  endfunction

  task automatic clear_mon();
    rx_q.delete(); fsp_q.delete(); rise_q.delete(); fall_q.delete();
  endtask

  task automatic burst(input logic [31:0] vals[$]);
    foreach (vals[i]) begin
      @(negedge clk);
      din = vals[i];
      din_valid = 1'b1;
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (rx_q.size() >= n) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && fifo_level == 0) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; din_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({sck, sdata, fs, overflow, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got sck/sdata/fs/ovf/busy=%b required 00000",
               {sck, sdata, fs, overflow, busy});
    end
    n_checks++;
    if (fifo_level !== 4'd0) begin
      n_fail++; $display("FAIL reset_level: got %0d required 0", fifo_level);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int first_fs = -1, fs_cnt = 0, last_fall = -1, idle_k = -1;
    bit prev_sck = 0, sdata2 = 1;
    logic [31:0] ew;
    enable = 1'b1;
    clear_mon();
    @(negedge clk); din = 32'h0012_3456; din_valid = 1'b1;
    @(negedge clk); din_valid = 1'b0;
    for (int k = 1; k <= SHIFT_CYC + GAP_CYC + 12; k++) begin
      @(negedge clk);
      if (fs) begin
        fs_cnt++;
        if (first_fs < 0) begin first_fs = k; sdata2 = sdata; end
      end
      if (prev_sck && !sck) last_fall = k;
      if (last_fall > 0 && idle_k < 0 && !busy && k > last_fall) idle_k = k;
      prev_sck = sck;
    end
    ew = exp_word(32'h0012_3456);
    $display("single: fs_first=%0d fs_cycles=%0d last_fall=%0d idle=%0d word=%h",
             first_fs, fs_cnt, last_fall, idle_k, (rx_q.size() > 0) ? rx_q[0] : 32'h0);
    n_checks++;
    if (first_fs != 2) begin n_fail++; $display("FAIL single_latency: got %0d required 2", first_fs); end
    n_checks++;
    if (fs_cnt != 2 * SCK_DIV) begin n_fail++; $display("FAIL single_fs_len: got %0d required %0d", fs_cnt, 2 * SCK_DIV); end
    n_checks++;
    if (sdata2 !== ew[NBITS-1]) begin n_fail++; $display("FAIL single_msb: got %b required %b", sdata2, ew[NBITS-1]); end
    n_checks++;
    if (last_fall != 2 + SHIFT_CYC) begin n_fail++; $display("FAIL single_shift_len: got %0d required %0d", last_fall, 2 + SHIFT_CYC); end
    n_checks++;
    if (idle_k != 2 + SHIFT_CYC + GAP_CYC) begin n_fail++; $display("FAIL single_gap: got %0d required %0d", idle_k, 2 + SHIFT_CYC + GAP_CYC); end
    n_checks++;
    if (rx_q.size() != 1 || rx_q[0] !== ew) begin
      n_fail++; $display("FAIL single_word: got n=%0d %h required n=1 %h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 32'h0, ew);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] vals[$] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFB};
    bit ok;
    enable = 1'b1;
    clear_mon();
    burst(vals);
    wait_frames(3, 3 * FRAME_BUDGET, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL sat_timeout: got %0d frames required 3", rx_q.size()); end
    foreach (vals[i]) begin
      $display("saturation: din=%h got %h exp %h", vals[i], (i < rx_q.size()) ? rx_q[i] : 32'h0, exp_word(vals[i]));
      n_checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_word(vals[i])) begin
        n_fail++; $display("FAIL sat_word%0d: got %h required %h", i, (i < rx_q.size()) ? rx_q[i] : 32'h0, exp_word(vals[i]));
      end
    end
    wait_idle(FRAME_BUDGET, ok);
  endtask

  task automatic test_overflow();
    logic [31:0] vals[$];
    bit ok;
    wait_idle(3 * FRAME_BUDGET, ok);
    enable = 1'b0;
    clear_mon();
    for (int i = 1; i <= 9; i++) vals.push_back(32'(i));
    burst(vals);
    n_checks++;
    if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d required 8", fifo_level); end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b required 1", overflow); end
    enable = 1'b1;
    wait_frames(8, 8 * FRAME_BUDGET, ok);
    wait_idle(2 * FRAME_BUDGET, ok);
    repeat (50) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 8) begin n_fail++; $display("FAIL ovf_count: got %0d frames required 8", rx_q.size()); end
    for (int i = 0; i < 8; i++) begin
      $display("overflow drain: frame %0d got %h exp %h", i, (i < rx_q.size()) ? rx_q[i] : 32'h0, exp_word(32'(i + 1)));
      n_checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_word(32'(i + 1))) begin
        n_fail++; $display("FAIL ovf_word%0d: got %h required %h", i, (i < rx_q.size()) ? rx_q[i] : 32'h0, exp_word(32'(i + 1)));
      end
    end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
  endtask

  task automatic test_full_pop();
    logic [31:0] vals[$];
    bit ok;
    reset = 1'b1; repeat (2) @(negedge clk); reset = 1'b0;
    enable = 1'b0;
    clear_mon();
    for (int i = 0; i < 8; i++) vals.push_back($urandom);
    burst(vals);
    n_checks++;
    if (fifo_level !== 4'd8 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL fullpop_pre: got level=%0d ovf=%b required 8/0", fifo_level, overflow);
    end
    enable = 1'b1;
    @(negedge clk);              // serializer is now in its load cycle
    vals.push_back($urandom);
    din = vals[8]; din_valid = 1'b1;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL fullpop_busy: got %b required 1", busy); end
    @(negedge clk);
    din_valid = 1'b0;
    n_checks++;
    if (overflow !== 1'b0 || fifo_level !== 4'd8) begin
      n_fail++; $display("FAIL fullpop_accept: got ovf=%b level=%0d required 0/8", overflow, fifo_level);
    end
    wait_frames(9, 9 * FRAME_BUDGET, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL fullpop_timeout: got %0d frames required 9", rx_q.size()); end
    foreach (vals[i]) begin
      $display("full+pop: frame %0d din=%h got %h exp %h", i, vals[i], (i < rx_q.size()) ? rx_q[i] : 32'h0, exp_word(vals[i]));
      n_checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_word(vals[i])) begin
        n_fail++; $display("FAIL fullpop_word%0d: got %h required %h", i, (i < rx_q.size()) ? rx_q[i] : 32'h0, exp_word(vals[i]));
      end
    end
    wait_idle(FRAME_BUDGET, ok);
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals[$];
    bit ok;
    wait_idle(2 * FRAME_BUDGET, ok);
    enable = 1'b1;
    clear_mon();
    vals = '{32'h0000_0001, $urandom, $urandom};
    burst(vals);
    wait_frames(3, 3 * FRAME_BUDGET, ok);
    repeat (4) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 3 || rise_q.size() != 3 || fall_q.size() != 3) begin
      n_fail++; $display("FAIL b2b_count: got frames=%0d rises=%0d falls=%0d required 3/3/3", rx_q.size(), rise_q.size(), fall_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        $display("b2b: frame %0d din=%h got %h exp %h fs_rise=%0d last_fall=%0d", i, vals[i], rx_q[i], exp_word(vals[i]), rise_q[i], fall_q[i]);
        n_checks++;
        if (rx_q[i] !== exp_word(vals[i])) begin n_fail++; $display("FAIL b2b_word%0d: got %h required %h", i, rx_q[i], exp_word(vals[i])); end
        n_checks++;
        if (fsp_q[i] !== (32'd1 << (NBITS - 1))) begin n_fail++; $display("FAIL b2b_fs%0d: got %h required %h", i, fsp_q[i], 32'd1 << (NBITS - 1)); end
        n_checks++;
        if (fall_q[i] - rise_q[i] != SHIFT_CYC) begin n_fail++; $display("FAIL b2b_len%0d: got %0d required %0d", i, fall_q[i] - rise_q[i], SHIFT_CYC); end
        if (i > 0) begin
          n_checks++;
          if (rise_q[i] - fall_q[i-1] != GAP_CYC + 1) begin
            n_fail++; $display("FAIL b2b_space%0d: got %0d required %0d", i, rise_q[i] - fall_q[i-1], GAP_CYC + 1);
          end
        end
      end
`ifdef SERIALIZER_PARITY_EN
      n_checks++;
      if (rx_q[0][0] !== 1'b1) begin n_fail++; $display("FAIL b2b_parity: got %b required 1", rx_q[0][0]); end
`endif
    end
  endtask

  task automatic test_random();
    logic [31:0] vals[$];
    logic [31:0] edge_vals[4] = '{32'h007F_FFFF, 32'h0080_0000, 32'hFF80_0000, 32'hFF7F_FFFF};
    bit ok;
    for (int r = 0; r < 3; r++) begin
      wait_idle(2 * FRAME_BUDGET, ok);
      enable = 1'b0;
      clear_mon();
      vals.delete();
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) begin
        case ($urandom_range(0, 2))
          0:       vals.push_back($urandom);
          1:       vals.push_back(32'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000);
          default: vals.push_back(edge_vals[$urandom_range(0, 3)]);
        endcase
      end
      foreach (vals[i]) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk); din = vals[i]; din_valid = 1'b1;
        @(negedge clk); din_valid = 1'b0;
      end
      enable = 1'b1;
      wait_frames(vals.size(), vals.size() * FRAME_BUDGET, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rand%0d_timeout: got %0d frames required %0d", r, rx_q.size(), vals.size()); end
      foreach (vals[i]) begin
        $display("random r%0d: frame %0d din=%h got %h exp %h", r, i, vals[i], (i < rx_q.size()) ? rx_q[i] : 32'h0, exp_word(vals[i]));
        n_checks++;
        if (i >= rx_q.size() || rx_q[i] !== exp_word(vals[i])) begin
          n_fail++; $display("FAIL rand%0d_word%0d: got %h required %h", r, i, (i < rx_q.size()) ? rx_q[i] : 32'h0, exp_word(vals[i]));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] vals[$];
    bit ok;
    int activity = 0;
    wait_idle(2 * FRAME_BUDGET, ok);
    enable = 1'b1;
    clear_mon();
    vals = '{$urandom, $urandom, $urandom};
    burst(vals);
    ok = 0;
    for (int i = 0; i < FRAME_BUDGET; i++) begin
      @(negedge clk);
      if (m_bits >= 10) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rmid_reach: got %0d bits required 10", m_bits); end
    repeat (SCK_DIV + 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    $display("reset mid-frame: sck=%b sdata=%b fs=%b level=%0d ovf=%b busy=%b", sck, sdata, fs, fifo_level, overflow, busy);
    n_checks++;
    if ({sck, sdata, fs, overflow, busy} !== 5'b0 || fifo_level !== 4'd0) begin
      n_fail++; $display("FAIL rmid_outputs: got sck/sdata/fs/ovf/busy=%b level=%0d required 00000/0",
                         {sck, sdata, fs, overflow, busy}, fifo_level);
    end
    reset = 1'b0;
    clear_mon();
    for (int i = 0; i < 2 * FRAME_BUDGET; i++) begin
      @(negedge clk);
      if (sck || fs || busy) activity++;
    end
    n_checks++;
    if (activity != 0 || rx_q.size() != 0) begin
      n_fail++; $display("FAIL rmid_quiet: got active=%0d frames=%0d required 0/0", activity, rx_q.size());
    end
    vals = '{32'h0000_0ABC};
    burst(vals);
    wait_frames(1, FRAME_BUDGET, ok);
    n_checks++;
    if (!ok || rx_q[0] !== exp_word(32'h0000_0ABC)) begin
      n_fail++; $display("FAIL rmid_resume: got n=%0d %h required %h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 32'h0, exp_word(32'h0000_0ABC));
    end
    wait_idle(FRAME_BUDGET, ok);
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
